// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with memory-ready stalls.
// Optional macro PERF_COUNT_EN adds cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0]            cycle_cnt,
  output logic [31:0]            instr_cnt
`endif
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {known, alucontrol}; unknown functs fall back to add.
  function automatic logic [3:0] funct_dec(input logic [5:0] f);
    case (f)
      6'b100000: funct_dec = {1'b1, ALU_ADD};
      6'b100010: funct_dec = {1'b1, ALU_SUB};
      6'b100100: funct_dec = {1'b1, ALU_AND};
      6'b100101: funct_dec = {1'b1, ALU_OR};
      6'b101010: funct_dec = {1'b1, ALU_SLT};
      default:   funct_dec = {1'b0, ALU_ADD};
    endcase
  endfunction

  logic [3:0] state, state_n;
  logic [3:0] fdec;
  logic [2:0] alu_q;

  logic       mem_req_c, iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c;
  logic       regwrite_c, alusrca_c, pcwrite_c, branch_c, illegal_c, pcen_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] alucontrol_c;

  assign fdec = funct_dec(bus.funct);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_n;
  end

  // R-type ALU op is captured in execute so writeback keeps driving it.
  always_ff @(posedge clk) begin
    if (state == S_RTYPEEX) alu_q <= fdec[2:0];
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQ;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_n = S_MEMRD;
        else if (bus.op == OP_SW) state_n = S_MEMWR;
        else                      state_n = S_FETCH;
      end
      S_MEMRD:   state_n = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_n = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_n = fdec[3] ? S_RTYPEWB : S_FETCH;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c    = 1'b0;
    iord_c       = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = 3'b000;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    illegal_c    = 1'b0;
    // Everything stays low while reset is held, even though state reads FETCH.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req_c    = 1'b1;
          alusrcb_c    = 2'b01;
          alucontrol_c = ALU_ADD;
          irwrite_c    = bus.mem_ready;
          pcwrite_c    = bus.mem_ready;
        end
        S_DECODE: begin
          alusrcb_c    = 2'b11;
          alucontrol_c = ALU_ADD;
          illegal_c    = !(bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_RTYPE ||
                           bus.op == OP_BEQ || bus.op == OP_ADDI || bus.op == OP_J);
        end
        S_MEMADR: begin
          alusrca_c    = 1'b1;
          alusrcb_c    = 2'b10;
          alucontrol_c = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg_c = 1'b1;
          regwrite_c = 1'b1;
        end
        S_MEMWR: begin
          mem_req_c  = 1'b1;
          iord_c     = 1'b1;
          memwrite_c = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca_c    = 1'b1;
          alucontrol_c = fdec[2:0];
          illegal_c    = ~fdec[3];
        end
        S_RTYPEWB: begin
          regdst_c     = 1'b1;
          regwrite_c   = 1'b1;
          alucontrol_c = alu_q;
        end
        S_BEQ: begin
          alusrca_c    = 1'b1;
          alucontrol_c = ALU_SUB;
          pcsrc_c      = 2'b01;
          branch_c     = 1'b1;
        end
        S_ADDIEX: begin
          alusrca_c    = 1'b1;
          alusrcb_c    = 2'b10;
          alucontrol_c = ALU_ADD;
        end
        S_ADDIWB: regwrite_c = 1'b1;
        S_JUMP: begin
          pcsrc_c   = 2'b10;
          pcwrite_c = 1'b1;
        end
        default: ;
      endcase
    end
    pcen_c = pcwrite_c | (branch_c & bus.zero);
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.iord       = iord_c;
  assign bus.memwrite   = memwrite_c;
  assign bus.irwrite    = irwrite_c;
  assign bus.regdst     = regdst_c;
  assign bus.memtoreg   = memtoreg_c;
  assign bus.regwrite   = regwrite_c;
  assign bus.alusrca    = alusrca_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.alucontrol = alucontrol_c;
  assign bus.pcen       = pcen_c;
  assign bus.illegal    = illegal_c;

`ifdef PERF_COUNT_EN
  logic retire;

  // An instruction retires when a terminal state (or an illegal decode) hands back to FETCH.
  assign retire = (state_n == S_FETCH) &&
                  (state == S_MEMWB   || state == S_MEMWR  || state == S_RTYPEWB ||
                   state == S_BEQ     || state == S_ADDIWB || state == S_JUMP    ||
                   state == S_DECODE  || state == S_RTYPEEX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle directed stimulus queues
// hand-computed output vectors; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

`ifdef PERF_COUNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master),
                            .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

  // Vector: mem_req iord memwrite irwrite regdst memtoreg regwrite alusrca
  //         alusrcb[2] pcsrc[2] alucontrol[3] pcen illegal
  localparam logic [16:0] X_ZERO   = 17'b0;
  localparam logic [16:0] X_FWAIT  = {8'b1000_0000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] X_FRDY   = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 2'b10};
  localparam logic [16:0] X_DEC    = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] X_DECILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 2'b01};
  localparam logic [16:0] X_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] X_MEMRD  = {8'b1100_0000, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] X_MEMWB  = {8'b0000_0110, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] X_MEMWR  = {8'b1110_0000, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] X_REXSLT = {8'b0000_0001, 2'b00, 2'b00, 3'b111, 2'b00};
  localparam logic [16:0] X_RWBSLT = {8'b0000_1010, 2'b00, 2'b00, 3'b111, 2'b00};
  localparam logic [16:0] X_REXSUB = {8'b0000_0001, 2'b00, 2'b00, 3'b110, 2'b00};
  localparam logic [16:0] X_RWBSUB = {8'b0000_1010, 2'b00, 2'b00, 3'b110, 2'b00};
  localparam logic [16:0] X_REXILL = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 2'b01};
  localparam logic [16:0] X_BEQT   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b10};
  localparam logic [16:0] X_BEQN   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b00};
  localparam logic [16:0] X_ADDIEX = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] X_ADDIWB = {8'b0000_0010, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] X_JUMP   = {8'b0000_0000, 2'b00, 2'b10, 3'b000, 2'b10};

  typedef struct {
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] observed();
    return {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
            bus.pcen, bus.illegal};
  endfunction

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic mr,
                      input logic z, input logic r, input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    reset         = r;
    bus.op        = o;
    bus.funct     = f;
    bus.mem_ready = mr;
    bus.zero      = z;
    sbq.push_back('{exp: e, name: nm});
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t item;
      logic [16:0] got;
      item = sbq.pop_front();
      got  = observed();
      checks++;
      if (got !== item.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", item.name, got, item.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.op = 6'b0; bus.funct = 6'b0; bus.mem_ready = 1'b0; bus.zero = 1'b0;

    step(6'b000000, 6'b0, 1'b1, 1'b0, 1'b1, X_ZERO, "reset_outputs");

    // lw with one fetch stall
    step(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, X_FWAIT,  "lw_fetch_wait");
    step(6'b100011, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "lw_fetch");
    step(6'b100011, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,    "lw_decode");
    step(6'b100011, 6'b0, 1'b1, 1'b0, 1'b0, X_MEMADR, "lw_memadr");
    step(6'b100011, 6'b0, 1'b1, 1'b0, 1'b0, X_MEMRD,  "lw_memrd");
    step(6'b100011, 6'b0, 1'b1, 1'b0, 1'b0, X_MEMWB,  "lw_memwb");

    // sw with three write stalls
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "sw_fetch");
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,    "sw_decode");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMADR, "sw_memadr");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMWR,  "sw_memwr_w1");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMWR,  "sw_memwr_w2");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMWR,  "sw_memwr_w3");
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_MEMWR,  "sw_memwr_done");
    step(6'b000000, 6'b101010, 1'b1, 1'b0, 1'b0, X_FRDY, "sw_back_to_fetch");

    // slt
    step(6'b000000, 6'b101010, 1'b1, 1'b0, 1'b0, X_DEC,    "slt_decode");
    step(6'b000000, 6'b101010, 1'b1, 1'b0, 1'b0, X_REXSLT, "slt_ex");
    step(6'b000000, 6'b100000, 1'b1, 1'b0, 1'b0, X_RWBSLT, "slt_wb_held");

    // sub
    step(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0, X_FRDY,   "sub_fetch");
    step(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0, X_DEC,    "sub_decode");
    step(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0, X_REXSUB, "sub_ex");
    step(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0, X_RWBSUB, "sub_wb");

    // beq taken then not taken
    step(6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, X_FRDY, "beq1_fetch");
    step(6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, X_DEC,  "beq1_decode");
    step(6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, X_BEQT, "beq_taken");
    step(6'b000100, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY, "beq2_fetch");
    step(6'b000100, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,  "beq2_decode");
    step(6'b000100, 6'b0, 1'b1, 1'b0, 1'b0, X_BEQN, "beq_not_taken");

    // addi and j
    step(6'b001000, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "addi_fetch");
    step(6'b001000, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,    "addi_decode");
    step(6'b001000, 6'b0, 1'b1, 1'b0, 1'b0, X_ADDIEX, "addi_ex");
    step(6'b001000, 6'b0, 1'b1, 1'b0, 1'b0, X_ADDIWB, "addi_wb");
    step(6'b000010, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "j_fetch");
    step(6'b000010, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,    "j_decode");
    step(6'b000010, 6'b0, 1'b1, 1'b0, 1'b0, X_JUMP,   "j_jump");

    // illegal opcode and illegal funct
    step(6'b111111, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "illop_fetch");
    step(6'b111111, 6'b0, 1'b1, 1'b0, 1'b0, X_DECILL, "illop_decode");
    step(6'b000000, 6'b000111, 1'b1, 1'b0, 1'b0, X_FRDY,   "illop_refetch");
    step(6'b000000, 6'b000111, 1'b1, 1'b0, 1'b0, X_DEC,    "illfn_decode");
    step(6'b000000, 6'b000111, 1'b1, 1'b0, 1'b0, X_REXILL, "illfn_ex");
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "illfn_refetch");

    // sw aborted by reset while write is stalled
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_DEC,    "swr_decode");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMADR, "swr_memadr");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_MEMWR,  "swr_memwr");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, X_ZERO,   "swr_reset_now");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, X_ZERO,   "swr_reset_hold");
    step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, X_FWAIT,  "swr_after_release");
    step(6'b101011, 6'b0, 1'b1, 1'b0, 1'b0, X_FRDY,   "swr_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
